m5_seq_checker: RTL and testbench

M5_SEQ_CHECKER -- requirements
Module: m5_seq_checker

---
 rtl/m5_pkg.sv | 22 ++
 rtl/sat_cnt8.sv | 20 ++
 rtl/m5_seq_checker.sv | 119 +++++++++++
 tb/tb_m5_seq_checker.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/m5_pkg.sv
// Shared definitions for the mod-N sequence checker: state encoding,
// default modulus and counter width.
package m5_pkg;

  localparam int unsigned MOD_DEF = 5;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned Q_W     = 3;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  // Successor of v in a mod-m count sequence (m-1 wraps to 0).
  function automatic logic [Q_W-1:0] succ_mod(input logic [Q_W-1:0] v,
                                              input int unsigned    m);
    if (v == Q_W'(m - 1)) succ_mod = '0;
    else                  succ_mod = v + 1'b1;
  endfunction

endpackage

// File: rtl/sat_cnt8.sv
// 8-bit up counter that sticks at all-ones, with synchronous clear
// taking priority over increment.
module sat_cnt8
  import m5_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count register: clear wins, otherwise increment until saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && (cnt != '1)) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/m5_seq_checker.sv
// Monitors the qout/z pair of an upstream mod-MOD counter, locks after
// LOCK_CNT consecutive correct samples, and reports violations while locked.
module m5_seq_checker
  import m5_pkg::*;
#(
  parameter int unsigned MOD      = MOD_DEF,
  parameter int unsigned LOCK_CNT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Q_W-1:0]   qin,
  input  logic             zin,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] wrap_cnt
);

  localparam int unsigned MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  state_t         state, state_n;
  logic [MW-1:0]  mcnt, mcnt_n;
  logic [Q_W-1:0] prev, prev_n;
  logic           err_n;
  logic           wrap_inc;
  logic           is_last;
  logic           valid;
  logic           correct;

  // Sample classification against the upstream counter's rules.
  always_comb begin
    is_last = (qin == Q_W'(MOD - 1));
    valid   = ({1'b0, qin} < (Q_W + 1)'(MOD)) && (zin == is_last);
    correct = valid && (qin == succ_mod(prev, MOD));
  end

  // Next-state, match count, previous-sample and event decode.
  always_comb begin
    state_n  = state;
    mcnt_n   = mcnt;
    prev_n   = prev;
    err_n    = 1'b0;
    wrap_inc = 1'b0;
    case (state)
      HUNT: begin
        if (valid) begin
          prev_n  = qin;
          mcnt_n  = '0;
          state_n = SYNC;
        end
      end
      SYNC: begin
        if (correct) begin
          prev_n = qin;
          if (mcnt == MW'(LOCK_CNT - 1)) begin
            mcnt_n  = '0;
            state_n = LOCK;
          end else begin
            mcnt_n = mcnt + 1'b1;
          end
        end else begin
          mcnt_n  = '0;
          state_n = HUNT;
        end
      end
      LOCK: begin
        if (correct) begin
          prev_n   = qin;
          wrap_inc = is_last;
        end else begin
          err_n   = 1'b1;
          state_n = HUNT;
        end
      end
      default: begin
        mcnt_n  = '0;
        state_n = HUNT;
      end
    endcase
  end

  // FSM state, match count and previous sample registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      mcnt  <= '0;
      prev  <= '0;
    end else begin
      state <= state_n;
      mcnt  <= mcnt_n;
      prev  <= prev_n;
    end
  end

  // Registered one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err_n;
  end

  // Wrapping count of correct terminal samples while locked; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        wrap_cnt <= '0;
    else if (clr_cnt)  wrap_cnt <= '0;
    else if (wrap_inc) wrap_cnt <= wrap_cnt + 1'b1;
  end

  assign locked = (state == LOCK);

  sat_cnt8 u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (err_n),
    .cnt   (err_cnt)
  );

endmodule

// File: tb/tb_m5_seq_checker.sv
// Self-checking bench for m5_seq_checker: behavioural reference model,
// per-cycle compare, directed scenarios and randomized upstream traffic.
module tb_m5_seq_checker;

  localparam int MODV = 5;
  localparam int LCK  = 5;

  logic       clk;
  logic       rst_n;
  logic [2:0] qin;
  logic       zin;
  logic       clr_cnt;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt;

  int vectors  = 0;
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  m5_seq_checker #(.MOD(MODV), .LOCK_CNT(LCK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .qin      (qin),
    .zin      (zin),
    .clr_cnt  (clr_cnt),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt),
    .wrap_cnt (wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: anchored/streak/locked view of the rules.
  int m_prev   = 0;
  bit m_anchor = 0;
  int m_streak = 0;
  bit m_locked = 0;
  bit exp_err  = 0;
  int exp_errc = 0;
  int exp_wrap = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = 0; m_anchor = 0; m_streak = 0; m_locked = 0;
      exp_err = 0; exp_errc = 0; exp_wrap = 0;
    end else begin
      int  q;
      bit  v, good;
      q    = int'(qin);
      v    = (q < MODV) && (zin == (q == MODV - 1));
      good = v && m_anchor && (q == (m_prev + 1) % MODV);
      exp_err = 0;
      if (m_locked) begin
        if (good) begin
          m_prev = q;
          if (q == MODV - 1) exp_wrap = (exp_wrap + 1) % 256;
        end else begin
          exp_err  = 1;
          m_locked = 0;
          m_anchor = 0;
          if (exp_errc < 255) exp_errc++;
        end
      end else if (m_anchor) begin
        if (good) begin
          m_prev = q;
          m_streak++;
          if (m_streak == LCK) m_locked = 1;
        end else begin
          m_anchor = 0;
          m_streak = 0;
        end
      end else if (v) begin
        m_anchor = 1;
        m_prev   = q;
        m_streak = 0;
      end
      if (clr_cnt) begin
        exp_errc = 0;
        exp_wrap = 0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare away from the sampling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_locked",   int'(locked),   int'(m_locked));
      check("cyc_err",      int'(err),      int'(exp_err));
      check("cyc_err_cnt",  int'(err_cnt),  exp_errc);
      check("cyc_wrap_cnt", int'(wrap_cnt), exp_wrap);
    end
  end

  // Apply one sample; returns #1 after the edge that captured it.
  task automatic step(input int q, input bit z, input bit c);
    qin     = 3'(q);
    zin     = z;
    clr_cnt = c;
    vectors++;
    @(posedge clk);
    #1;
  endtask

  task automatic up(input int q, input bit c);
    step(q, (q == MODV - 1), c);
  endtask

  int saved;
  int u;

  initial begin
    rst_n = 1'b0; qin = 3'd7; zin = 1'b0; clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_locked",   int'(locked),   0);
    check("rst_err",      int'(err),      0);
    check("rst_err_cnt",  int'(err_cnt),  0);
    check("rst_wrap_cnt", int'(wrap_cnt), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1;
    @(posedge clk);
    #1;

    // Clean upstream count 0..4,0,1: lock after the 5th correct sample.
    for (int i = 0; i < 5; i++) begin
      up(i, 0);
      check("acq_not_locked", int'(locked), 0);
    end
    up(0, 0);
    check("acq_locked", int'(locked), 1);
    check("acq_err", int'(err), 0);
    up(1, 0);
    check("acq_hold", int'(locked), 1);

    // Jump 2 -> 4 while locked.
    up(2, 0);
    check("wrap_after_acq", int'(wrap_cnt), 0);
    up(4, 0);
    check("jump_err", int'(err), 1);
    check("jump_err_cnt", int'(err_cnt), 1);
    check("jump_unlock", int'(locked), 0);
    up(0, 0);
    check("jump_err_once", int'(err), 0);
    for (int i = 1; i < 5; i++) begin
      up(i, 0);
      check("relock_wait", int'(locked), 0);
    end
    up(0, 0);
    check("relock", int'(locked), 1);

    // Terminal value without the terminal flag.
    up(1, 0); up(2, 0); up(3, 0);
    saved = int'(wrap_cnt);
    step(4, 0, 0);
    check("noz_err", int'(err), 1);
    check("noz_wrap", int'(wrap_cnt), saved);
    check("noz_err_cnt", int'(err_cnt), 2);

    // Clear coincident with a wrap sample.
    for (int i = 0; i < 5; i++) up(i, 0);
    up(0, 0);
    up(1, 0); up(2, 0); up(3, 0);
    up(4, 1);
    check("clr_wrap", int'(wrap_cnt), 0);
    check("clr_err_cnt", int'(err_cnt), 0);
    check("clr_locked", int'(locked), 1);

    // 300 full cycles while locked.
    up(0, 1);
    for (int i = 0; i < 300 * MODV; i++) up((i + 1) % MODV, 0);
    check("wrap_300", int'(wrap_cnt), 44);

    // 260 forced errors, relocking between each.
    for (int e = 0; e < 260; e++) begin
      step(7, 0, 0);
      for (int i = 0; i < 5; i++) up(i, 0);
      up(0, 0);
    end
    check("err_sat", int'(err_cnt), 255);
    check("err_sat_locked", int'(locked), 1);

    // Randomized upstream traffic with glitches and clears.
    u = 0;
    for (int n = 0; n < 3000; n++) begin
      bit c;
      c = ($urandom_range(99) < 3);
      if ($urandom_range(99) < 8) begin
        step(int'($urandom_range(7)), bit'($urandom_range(1)), c);
      end else begin
        up(u, c);
        u = (u + 1) % MODV;
      end
    end

    // Async reset in the middle of lock.
    for (int i = 0; i < 12; i++) up(i % MODV, 0);
    check("pre_rst_locked", int'(locked), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_locked",   int'(locked),   0);
    check("arst_err_cnt",  int'(err_cnt),  0);
    check("arst_wrap_cnt", int'(wrap_cnt), 0);
    qin = 3'd7; zin = 1'b0; clr_cnt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      up(i, 0);
      check("post_rst_unlocked", int'(locked), 0);
    end
    up(0, 0);
    check("post_rst_relock", int'(locked), 1);

    @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, n_fail);
    $finish;
  end

endmodule
